aho_table_writer: RTL and testbench

Loads the Aho-Corasick goto and failure tables from a host-side valid/ready stream into on-chip RAMs. The same RAMs are exposed through synchronous read ports to the table-reader stages. The block owns table population, ordering checks and the table-valid flag; readers are only used while TABLE_VALID=1.

---
 rtl/aho_table_pkg.sv | 30 +++
 rtl/aho_table_ram.sv | 40 ++++
 rtl/aho_table_writer.sv | 192 +++++++++++++++++++
 tb/tb_aho_table_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aho_table_pkg.sv
// Shared types and sizes for the Aho-Corasick table writer.
// Holds table geometry, beat-kind constants, the loader FSM encoding
// and the packed goto-entry layout stored in the goto RAM.
package aho_table_pkg;

    localparam int unsigned DEPTH   = 32;
    localparam int unsigned STATE_W = 8;
    localparam int unsigned CHARA_W = 4;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned GOTO_W  = STATE_W + CHARA_W + STATE_W;
    localparam int unsigned CSUM_W  = 8;

    localparam logic KIND_GOTO = 1'b0;
    localparam logic KIND_FAIL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GOTO = 2'd1,
        ST_FAIL = 2'd2,
        ST_DONE = 2'd3
    } aho_state_e;

    typedef struct packed {
        logic [STATE_W-1:0] cur;
        logic [CHARA_W-1:0] chara;
        logic [STATE_W-1:0] nxt;
    } goto_entry_t;

endpackage

// File: rtl/aho_table_ram.sv
// Single-write / single-read synchronous RAM.
// Ports: clk_i, rst_ni (clears only the read register), we_i/waddr_i/wdata_i
// write port, raddr_i read address, rdata_o read data one cycle later.
// Reads see the old contents when the same address is written that cycle.
module aho_table_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array: contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register, always enabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/aho_table_writer.sv
// Loads Aho-Corasick goto and failure tables from a valid/ready host stream
// and exposes both tables through synchronous read ports.
// Ports: CLK/RST (async active-low), START load pulse, WR_* write stream,
// RD_ADDR -> RD_CUR/RD_CHARA/RD_NEXT goto read, RD_FADDR -> RD_FAIL failure
// read, GOTO_COUNT, TABLE_VALID, sticky ERR_OVF/ERR_ORDER, CHECKSUM.
// Optional macro AHO_TABLE_CHECKSUM_EN enables the CHECKSUM accumulator;
// without it CHECKSUM is constant zero.
module aho_table_writer
    import aho_table_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               WR_VALID,
    output logic               WR_READY,
    input  logic               WR_KIND,
    input  logic [STATE_W-1:0] WR_CUR,
    input  logic [CHARA_W-1:0] WR_CHARA,
    input  logic [STATE_W-1:0] WR_NEXT,
    input  logic               WR_LAST,
    input  logic [ADDR_W-1:0]  RD_ADDR,
    output logic [STATE_W-1:0] RD_CUR,
    output logic [CHARA_W-1:0] RD_CHARA,
    output logic [STATE_W-1:0] RD_NEXT,
    input  logic [ADDR_W-1:0]  RD_FADDR,
    output logic [STATE_W-1:0] RD_FAIL,
    output logic [CNT_W-1:0]   GOTO_COUNT,
    output logic               TABLE_VALID,
    output logic               ERR_OVF,
    output logic               ERR_ORDER,
    output logic [CSUM_W-1:0]  CHECKSUM
);

    aho_state_e         state_q, state_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tvalid_q, tvalid_d;
    logic               ovf_q, ovf_d;
    logic               order_q, order_d;

    logic               goto_we;
    logic               fail_we;
    logic [ADDR_W-1:0]  fail_waddr;
    logic               accept;
    goto_entry_t        goto_wdata;
    goto_entry_t        goto_rdata;

    // READY is registered, so acceptance never loops back through WR_VALID.
    assign accept     = WR_VALID && ready_q;
    assign fail_waddr = ADDR_W'(WR_CUR - STATE_W'(1));
    assign goto_wdata = '{cur: WR_CUR, chara: WR_CHARA, nxt: WR_NEXT};

    // Next-state and write-enable decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tvalid_d = tvalid_q;
        ovf_d    = ovf_q;
        order_d  = order_q;
        goto_we  = 1'b0;
        fail_we  = 1'b0;

        if (START) begin
            // START wins over any coincident beat.
            state_d  = ST_GOTO;
            cnt_d    = '0;
            tvalid_d = 1'b0;
            ovf_d    = 1'b0;
            order_d  = 1'b0;
        end else if (accept) begin
            unique case (state_q)
                ST_GOTO: begin
                    if (WR_KIND == KIND_GOTO) begin
                        if (cnt_q < CNT_W'(DEPTH)) begin
                            goto_we = 1'b1;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        order_d = 1'b1;
                    end
                    if (WR_LAST) begin
                        state_d = ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    if (WR_KIND == KIND_FAIL) begin
                        if ((WR_CUR == '0) || (WR_CUR > STATE_W'(DEPTH))) begin
                            order_d = 1'b1;
                        end else begin
                            fail_we = 1'b1;
                        end
                    end else begin
                        order_d = 1'b1;
                    end
                    if (WR_LAST) begin
                        state_d  = ST_DONE;
                        tvalid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        ready_d = (state_d == ST_GOTO) || (state_d == ST_FAIL);
    end

    // Control registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            order_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            ovf_q    <= ovf_d;
            order_q  <= order_d;
        end
    end

    assign WR_READY    = ready_q;
    assign GOTO_COUNT  = cnt_q;
    assign TABLE_VALID = tvalid_q;
    assign ERR_OVF     = ovf_q;
    assign ERR_ORDER   = order_q;

`ifdef AHO_TABLE_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;

    // XOR of written fields; the character is ignored on failure beats.
    always_comb begin
        csum_d = csum_q;
        if (START) begin
            csum_d = '0;
        end else if (goto_we) begin
            csum_d = csum_q ^ CSUM_W'(WR_CUR) ^ CSUM_W'(WR_NEXT) ^ CSUM_W'(WR_CHARA);
        end else if (fail_we) begin
            csum_d = csum_q ^ CSUM_W'(WR_CUR) ^ CSUM_W'(WR_NEXT);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign CHECKSUM = csum_q;
`else
    assign CHECKSUM = '0;
`endif

    aho_table_ram #(
        .WIDTH (GOTO_W),
        .DEPTH (DEPTH)
    ) u_goto_ram (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .we_i    (goto_we),
        .waddr_i (cnt_q[ADDR_W-1:0]),
        .wdata_i (goto_wdata),
        .raddr_i (RD_ADDR),
        .rdata_o (goto_rdata)
    );

    aho_table_ram #(
        .WIDTH (STATE_W),
        .DEPTH (DEPTH)
    ) u_fail_ram (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .we_i    (fail_we),
        .waddr_i (fail_waddr),
        .wdata_i (WR_NEXT),
        .raddr_i (RD_FADDR),
        .rdata_o (RD_FAIL)
    );

    assign RD_CUR   = goto_rdata.cur;
    assign RD_CHARA = goto_rdata.chara;
    assign RD_NEXT  = goto_rdata.nxt;

endmodule

// File: tb/tb_aho_table_writer.sv
// Directed self-checking bench for aho_table_writer.
module tb_aho_table_writer;
    import aho_table_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               wr_valid;
    logic               wr_ready;
    logic               wr_kind;
    logic [STATE_W-1:0] wr_cur;
    logic [CHARA_W-1:0] wr_chara;
    logic [STATE_W-1:0] wr_next;
    logic               wr_last;
    logic [ADDR_W-1:0]  rd_addr;
    logic [STATE_W-1:0] rd_cur;
    logic [CHARA_W-1:0] rd_chara;
    logic [STATE_W-1:0] rd_next;
    logic [ADDR_W-1:0]  rd_faddr;
    logic [STATE_W-1:0] rd_fail;
    logic [CNT_W-1:0]   goto_count;
    logic               table_valid;
    logic               err_ovf;
    logic               err_order;
    logic [CSUM_W-1:0]  checksum;

    int n_tests = 0;
    int n_fail  = 0;

    aho_table_writer dut (
        .CLK         (clk),
        .RST         (rst_n),
        .START       (start),
        .WR_VALID    (wr_valid),
        .WR_READY    (wr_ready),
        .WR_KIND     (wr_kind),
        .WR_CUR      (wr_cur),
        .WR_CHARA    (wr_chara),
        .WR_NEXT     (wr_next),
        .WR_LAST     (wr_last),
        .RD_ADDR     (rd_addr),
        .RD_CUR      (rd_cur),
        .RD_CHARA    (rd_chara),
        .RD_NEXT     (rd_next),
        .RD_FADDR    (rd_faddr),
        .RD_FAIL     (rd_fail),
        .GOTO_COUNT  (goto_count),
        .TABLE_VALID (table_valid),
        .ERR_OVF     (err_ovf),
        .ERR_ORDER   (err_order),
        .CHECKSUM    (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic kind, input logic [7:0] cur, input logic [3:0] chara,
                        input logic [7:0] nxt, input logic last);
        wr_valid = 1'b1;
        wr_kind  = kind;
        wr_cur   = cur;
        wr_chara = chara;
        wr_next  = nxt;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic read_goto(input logic [4:0] a);
        rd_addr = a;
        tick();
    endtask

    task automatic read_fail(input logic [4:0] a);
        rd_faddr = a;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        wr_valid = 1'b0;
        wr_kind  = 1'b0;
        wr_cur   = '0;
        wr_chara = '0;
        wr_next  = '0;
        wr_last  = 1'b0;
        rd_addr  = '0;
        rd_faddr = '0;
        #12;
        check_eq("rst_ready", 32'(wr_ready), 32'd0);
        check_eq("rst_count", 32'(goto_count), 32'd0);
        check_eq("rst_tvalid", 32'(table_valid), 32'd0);
        check_eq("rst_ovf", 32'(err_ovf), 32'd0);
        check_eq("rst_order", 32'(err_order), 32'd0);
        check_eq("rst_csum", 32'(checksum), 32'd0);
        check_eq("rst_rdcur", 32'(rd_cur), 32'd0);
        check_eq("rst_rdfail", 32'(rd_fail), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("idle_ready", 32'(wr_ready), 32'd0);

        // Basic load: 3 goto + 3 failure beats.
        pulse_start();
        check_eq("start_ready", 32'(wr_ready), 32'd1);
        beat(KIND_GOTO, 8'd0, 4'h1, 8'd1, 1'b0);
        beat(KIND_GOTO, 8'd1, 4'h2, 8'd2, 1'b0);
        beat(KIND_GOTO, 8'd0, 4'h3, 8'd3, 1'b1);
        check_eq("basic_count", 32'(goto_count), 32'd3);
        check_eq("basic_tv_mid", 32'(table_valid), 32'd0);
        check_eq("basic_ready_fail", 32'(wr_ready), 32'd1);
        beat(KIND_FAIL, 8'd1, 4'h0, 8'd0, 1'b0);
        beat(KIND_FAIL, 8'd2, 4'h0, 8'd0, 1'b0);
        beat(KIND_FAIL, 8'd3, 4'h0, 8'd1, 1'b1);
        check_eq("basic_tvalid", 32'(table_valid), 32'd1);
        check_eq("basic_ready_done", 32'(wr_ready), 32'd0);
        check_eq("basic_order", 32'(err_order), 32'd0);
        check_eq("basic_ovf", 32'(err_ovf), 32'd0);
        read_goto(5'd1);
        check_eq("rd1_cur", 32'(rd_cur), 32'd1);
        check_eq("rd1_chara", 32'(rd_chara), 32'h2);
        check_eq("rd1_next", 32'(rd_next), 32'd2);
        read_goto(5'd2);
        check_eq("rd2_chara", 32'(rd_chara), 32'h3);
        check_eq("rd2_next", 32'(rd_next), 32'd3);
        read_fail(5'd2);
        check_eq("rdf2", 32'(rd_fail), 32'd1);
        read_fail(5'd0);
        check_eq("rdf0", 32'(rd_fail), 32'd0);

        // START from DONE with a valid beat pending: beat must not be taken.
        wr_valid = 1'b1;
        wr_kind  = KIND_GOTO;
        wr_cur   = 8'd9;
        wr_chara = 4'h9;
        wr_next  = 8'd9;
        start    = 1'b1;
        tick();
        check_eq("sd_tvalid", 32'(table_valid), 32'd0);
        check_eq("sd_count", 32'(goto_count), 32'd0);
        check_eq("sd_ready", 32'(wr_ready), 32'd1);
        // Now in GOTO with READY high: START still beats the coincident beat.
        tick();
        check_eq("sg_count", 32'(goto_count), 32'd0);
        start    = 1'b0;
        wr_valid = 1'b0;

        // Overflow: 33 goto beats, last one dropped.
        for (int i = 0; i < 33; i++) begin
            beat(KIND_GOTO, 8'(i), 4'(i), 8'(i + 1), (i == 32));
        end
        check_eq("ovf_count", 32'(goto_count), 32'd32);
        check_eq("ovf_flag", 32'(err_ovf), 32'd1);
        check_eq("ovf_order", 32'(err_order), 32'd0);
        check_eq("ovf_ready", 32'(wr_ready), 32'd1);
        read_goto(5'd31);
        check_eq("ovf_rd31_cur", 32'(rd_cur), 32'd31);
        check_eq("ovf_rd31_chara", 32'(rd_chara), 32'hf);
        check_eq("ovf_rd31_next", 32'(rd_next), 32'd32);

        // Kind mismatch in GOTO; a mismatched LAST still advances the FSM.
        pulse_start();
        check_eq("km_clear_ovf", 32'(err_ovf), 32'd0);
        beat(KIND_FAIL, 8'd1, 4'h0, 8'd7, 1'b0);
        check_eq("km_order", 32'(err_order), 32'd1);
        check_eq("km_count", 32'(goto_count), 32'd0);
        beat(KIND_FAIL, 8'd1, 4'h0, 8'd7, 1'b1);
        beat(KIND_FAIL, 8'd1, 4'h0, 8'h11, 1'b1);
        check_eq("km_tvalid", 32'(table_valid), 32'd1);

        // Failure-beat range checks.
        pulse_start();
        check_eq("fr_clear_order", 32'(err_order), 32'd0);
        beat(KIND_GOTO, 8'd5, 4'h1, 8'd6, 1'b1);
        beat(KIND_FAIL, 8'd1, 4'h0, 8'h11, 1'b0);
        beat(KIND_FAIL, 8'd32, 4'h0, 8'h44, 1'b0);
        check_eq("fr_order_ok", 32'(err_order), 32'd0);
        beat(KIND_FAIL, 8'd0, 4'h0, 8'h55, 1'b0);
        check_eq("fr_order_zero", 32'(err_order), 32'd1);
        beat(KIND_FAIL, 8'd33, 4'h0, 8'h66, 1'b1);
        check_eq("fr_tvalid", 32'(table_valid), 32'd1);
        check_eq("fr_count", 32'(goto_count), 32'd1);
        read_fail(5'd31);
        check_eq("fr_rdf31", 32'(rd_fail), 32'h44);
        read_fail(5'd0);
        check_eq("fr_rdf0", 32'(rd_fail), 32'h11);

        // Reset mid-GOTO.
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            beat(KIND_GOTO, 8'(i), 4'(i), 8'(i), 1'b0);
        end
        check_eq("mr_count5", 32'(goto_count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mr_ready", 32'(wr_ready), 32'd0);
        check_eq("mr_count", 32'(goto_count), 32'd0);
        check_eq("mr_tvalid", 32'(table_valid), 32'd0);
        check_eq("mr_rdfail", 32'(rd_fail), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("mr_ready_idle", 32'(wr_ready), 32'd0);

        // Checksum: single goto beat (1,'h2,2).
        pulse_start();
        beat(KIND_GOTO, 8'd1, 4'h2, 8'd2, 1'b0);
`ifdef AHO_TABLE_CHECKSUM_EN
        check_eq("csum_one", 32'(checksum), 32'h01);
`else
        check_eq("csum_off", 32'(checksum), 32'h00);
`endif
        check_eq("csum_count", 32'(goto_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
